// File: rtl/table_sweep_checker.sv
// table_sweep_checker
//
// Sweeps every input vector of a 3- or 4-input combinational function,
// holds each vector for SETTLE cycles, then samples two implementations of
// the function (gate-level y_a and behavioural y_b).
//
// Each sample is compared against a truth table latched at sweep start.
// The block reports the captured table, per-index mismatch flags, a
// mismatch count and an overall pass flag.
//
// Handshake: start is a request that is only honoured in IDLE or DONE.
//   - The edge that accepts start clears all results, latches expected and
//     raises busy.
//   - done rises 2^NIN*(SETTLE+1) cycles after that edge.
//   - done stays high, with results stable, until the next accepted start
//     or reset.
//   - start during a sweep is ignored.
//
// Parameters
//   NIN     number of function inputs (3 or 4)
//   SETTLE  cycles each vector is held before sampling (1..15)
//
// Ports
//   clk          clock, all state changes on its rising edge
//   reset        synchronous active-high reset, takes priority over start
//   start        sweep request
//   expected     expected truth table, bit i = Y for input index i
//   y_a          gate-level function output
//   y_b          behavioural function output
//   abcd         driven input vector (NIN=3 uses bits 2..0, bit3 = 0)
//   busy         high in HOLD and SAMPLE
//   done         high in DONE
//   tabla        captured y_a per index
//   mism         per-index mismatch flags
//   mism_cnt     number of set bits in mism
//   pass         done with no mismatches
//   state_dbg_o  current FSM state, for debug and checker binding
module table_sweep_checker #(
   parameter int NIN    = 4,
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] expected,
   input  logic        y_a,
   input  logic        y_b,
   output logic [3:0]  abcd,
   output logic        busy,
   output logic        done,
   output logic [15:0] tabla,
   output logic [15:0] mism,
   output logic [4:0]  mism_cnt,
   output logic        pass,
   output logic [1:0]  state_dbg_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_IDX    = 4'((1 << NIN) - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  settle_q, settle_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] tabla_q, tabla_d;
   logic [15:0] mism_q, mism_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        flag;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         exp_q    <= '0;
         tabla_q  <= '0;
         mism_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         exp_q    <= exp_d;
         tabla_q  <= tabla_d;
         mism_q   <= mism_d;
         cnt_q    <= cnt_d;
      end
   end

   // A sample mismatches if the gate-level output disagrees with either the
   // latched expected table or the behavioural model.
   assign flag = (y_a != exp_q[idx_q]) || (y_a != y_b);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      exp_d    = exp_q;
      tabla_d  = tabla_q;
      mism_d   = mism_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               exp_d    = expected;
               tabla_d  = '0;
               mism_d   = '0;
               cnt_d    = '0;
               idx_d    = '0;
               settle_d = '0;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            // settle_q counts completed HOLD cycles minus one; the SETTLE-th
            // HOLD cycle hands over to SAMPLE.
            settle_d = settle_q + 4'd1;
            if (settle_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            tabla_d[idx_q] = y_a;
            mism_d[idx_q]  = flag;
            if (flag) begin
               cnt_d = cnt_q + 5'd1;
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d    = idx_q + 4'd1;
               settle_d = '0;
               state_d  = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // idx_q never exceeds LAST_IDX, so bit3 stays 0 when NIN=3.
   assign abcd        = (state_q == S_IDLE) ? 4'd0 : idx_q;
   assign busy        = (state_q == S_HOLD) || (state_q == S_SAMPLE);
   assign done        = (state_q == S_DONE);
   assign pass        = (state_q == S_DONE) && (cnt_q == 5'd0);
   assign tabla       = tabla_q;
   assign mism        = mism_q;
   assign mism_cnt    = cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_table_sweep_checker.sv
// Bench for table_sweep_checker.
// Two instances run: NIN=4/SETTLE=1 and NIN=3/SETTLE=2. The bench plays the
// function under test by looking up y_a/y_b in truth tables indexed by abcd.
module tb_table_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance 0: NIN=4, SETTLE=1
   logic        rst4, start4, ya4, yb4, busy4, done4, pass4;
   logic [15:0] exp4, fa4, fb4, tabla4, mism4;
   logic [3:0]  abcd4;
   logic [4:0]  cnt4;
   logic [1:0]  st4;
   // instance 1: NIN=3, SETTLE=2
   logic        rst3, start3, ya3, yb3, busy3, done3, pass3;
   logic [15:0] exp3, fa3, fb3, tabla3, mism3;
   logic [3:0]  abcd3;
   logic [4:0]  cnt3;
   logic [1:0]  st3;

   assign ya4 = fa4[abcd4];
   assign yb4 = fb4[abcd4];
   assign ya3 = fa3[abcd3];
   assign yb3 = fb3[abcd3];

   table_sweep_checker #(.NIN(4), .SETTLE(1)) u_dut4 (
      .clk(clk), .reset(rst4), .start(start4), .expected(exp4),
      .y_a(ya4), .y_b(yb4), .abcd(abcd4), .busy(busy4), .done(done4),
      .tabla(tabla4), .mism(mism4), .mism_cnt(cnt4), .pass(pass4),
      .state_dbg_o(st4)
   );

   table_sweep_checker #(.NIN(3), .SETTLE(2)) u_dut3 (
      .clk(clk), .reset(rst3), .start(start3), .expected(exp3),
      .y_a(ya3), .y_b(yb3), .abcd(abcd3), .busy(busy3), .done(done3),
      .tabla(tabla3), .mism(mism3), .mism_cnt(cnt3), .pass(pass3),
      .state_dbg_o(st3)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // scoreboard: {tabla, mism, mism_cnt, pass} and the cycle done must rise
   logic [37:0] exp_q4[$];
   logic [37:0] exp_q3[$];
   int          due_q4[$];
   int          due_q3[$];
   logic [1:0]  idle_st4, idle_st3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference: apply the sweep rules directly to whole truth tables.
   function automatic logic [37:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                         input logic [15:0] ex, input int nin);
      logic [15:0] t;
      logic [15:0] m;
      logic [4:0]  c;
      t = '0; m = '0; c = '0;
      for (int i = 0; i < (1 << nin); i++) begin
         t[i] = fa[i];
         m[i] = (fa[i] != ex[i]) || (fa[i] != fb[i]);
         if (m[i]) c = c + 5'd1;
      end
      return {t, m, c, (c == 5'd0)};
   endfunction

   // Y = A~C~D | AB | AC with A = bit3 .. D = bit0
   function automatic logic [15:0] tt_f4();
      logic [15:0] r;
      logic a, b, c, d;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         a = i[3]; b = i[2]; c = i[1]; d = i[0];
         r[i] = (a & ~c & ~d) | (a & b) | (a & c);
      end
      return r;
   endfunction

   // Y = ~B with A = bit2, B = bit1, C = bit0
   function automatic logic [15:0] tt_notb3();
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i] = ~i[1];
      return r;
   endfunction

   // monitor: pops an expectation on every rising edge of done
   task automatic mon_check(input int sel);
      logic [37:0] e;
      logic [37:0] act;
      logic [3:0]  ab;
      logic [3:0]  last;
      int          due;
      int          qs;
      if (sel == 0) begin
         act = {tabla4, mism4, cnt4, pass4}; ab = abcd4; last = 4'd15; qs = exp_q4.size();
      end else begin
         act = {tabla3, mism3, cnt3, pass3}; ab = abcd3; last = 4'd7; qs = exp_q3.size();
      end
      chk($sformatf("sb_nonempty%0d", sel), (qs != 0), 1);
      if (qs != 0) begin
         if (sel == 0) begin e = exp_q4.pop_front(); due = due_q4.pop_front(); end
         else begin e = exp_q3.pop_front(); due = due_q3.pop_front(); end
         chk($sformatf("tabla%0d", sel), act[37:22], e[37:22]);
         chk($sformatf("mism%0d", sel), act[21:6], e[21:6]);
         chk($sformatf("mism_cnt%0d", sel), act[5:1], e[5:1]);
         chk($sformatf("pass%0d", sel), act[0], e[0]);
         chk($sformatf("done_cycle%0d", sel), cyc, due);
         chk($sformatf("abcd_last%0d", sel), ab, last);
      end
   endtask

   logic done4_prev = 1'b0;
   logic done3_prev = 1'b0;
   always @(negedge clk) begin
      if (done4 && !done4_prev) mon_check(0);
      if (done3 && !done3_prev) mon_check(1);
      done4_prev <= done4;
      done3_prev <= done3;
   end

   // One full sweep: start, check cleared results, scramble expected while
   // busy (optionally pulse start mid-sweep), wait for done.
   task automatic run(input int sel, input logic [15:0] fa, input logic [15:0] fb,
                      input logic [15:0] ex, input bit mid);
      int  nin, s, acc;
      bit  ok;
      logic dn;
      nin = (sel == 0) ? 4 : 3;
      s   = (sel == 0) ? 1 : 2;
      @(negedge clk);
      if (sel == 0) begin fa4 = fa; fb4 = fb; exp4 = ex; start4 = 1'b1; end
      else begin fa3 = fa; fb3 = fb; exp3 = ex; start3 = 1'b1; end
      @(posedge clk); #1;
      acc = cyc;
      if (sel == 0) begin
         start4 = 1'b0;
         exp_q4.push_back(model(fa, fb, ex, nin));
         due_q4.push_back(acc + (1 << nin) * (s + 1));
         chk("start_clear0", {abcd4, busy4, done4, pass4, cnt4, tabla4, mism4},
             {4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 16'd0});
         chk("dbg_state_busy0", (st4 != idle_st4), 1);
      end else begin
         start3 = 1'b0;
         exp_q3.push_back(model(fa, fb, ex, nin));
         due_q3.push_back(acc + (1 << nin) * (s + 1));
         chk("start_clear1", {abcd3, busy3, done3, pass3, cnt3, tabla3, mism3},
             {4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 16'd0});
         chk("dbg_state_busy1", (st3 != idle_st3), 1);
      end
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (sel == 0) begin
            exp4 = 16'($urandom); start4 = mid && (c == 10); dn = done4;
         end else begin
            exp3 = 16'($urandom); start3 = mid && (c == 10); dn = done3;
         end
         if (dn) begin ok = 1'b1; break; end
      end
      if (sel == 0) start4 = 1'b0; else start3 = 1'b0;
      chk($sformatf("done_seen%0d", sel), ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] f, fb, ex;
      rst4 = 1'b1; rst3 = 1'b1; start4 = 1'b0; start3 = 1'b0;
      exp4 = '0; exp3 = '0; fa4 = '0; fb4 = '0; fa3 = '0; fb3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs0", {abcd4, busy4, done4, pass4, cnt4, tabla4, mism4}, 0);
      chk("reset_outs1", {abcd3, busy3, done3, pass3, cnt3, tabla3, mism3}, 0);
      idle_st4 = st4;
      idle_st3 = st3;
      @(negedge clk);
      rst4 = 1'b0; rst3 = 1'b0;

      // directed cases
      f = tt_f4();
      run(0, f, f, 16'hFD00, 1'b0);
      run(0, f, f, 16'hFF00, 1'b0);
      run(0, f, 16'h0000, 16'hFD00, 1'b0);
      run(0, f, f, 16'hFD00, 1'b1);      // start mid-sweep ignored
      run(1, tt_notb3(), tt_notb3(), 16'h0033, 1'b0);
      run(1, tt_notb3(), tt_notb3(), 16'h0033, 1'b1);

      // randomized sweeps
      for (int i = 0; i < 12; i++) begin
         f = 16'($urandom);
         case ($urandom_range(0, 2))
            0: fb = f;
            1: fb = f ^ (16'd1 << $urandom_range(0, 15));
            default: fb = 16'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0: ex = f;
            1: ex = f ^ (16'd1 << $urandom_range(0, 15));
            default: ex = 16'($urandom);
         endcase
         run(i % 2, f, fb, ex, 1'($urandom_range(0, 1)));
      end

      // reset mid-sweep at index 5, with start held high on the reset edge
      @(negedge clk);
      fa4 = 16'hFFFF; fb4 = 16'h0000; exp4 = 16'h5A5A; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (abcd4 == 4'd5) break;
      end
      chk("reach_idx5", abcd4, 5);
      rst4 = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      chk("abort_clear", {abcd4, busy4, done4, pass4, cnt4, tabla4, mism4}, 0);
      @(negedge clk);
      rst4 = 1'b0; start4 = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_abort", {busy4, done4, abcd4}, 0);
      run(0, tt_f4(), tt_f4(), 16'hFD00, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", exp_q4.size() + exp_q3.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
